// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: parametrised LCD image controller.
// Loads an IMG_W x IMG_H image from IROM, applies 2x2 window commands around a
// movable operation point, and dumps the buffer to IRAM on Write.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_LOAD  | stream IROM addresses 0..N-1, capture data one cycle later
// S_IDLE  | waiting for a command (busy low)
// S_EXEC  | one-cycle execution of a move/window/NOP command
// S_WRITE | stream buffer to IRAM addresses 0..N-1
// S_DONE  | terminal; busy and done held high until rst
module lcd_ctrl_param #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = $clog2(IMG_W*IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    input  logic [DW-1:0] IROM_Q,
    output logic          IRAM_ceb,
    output logic          IRAM_web,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    input  logic [DW-1:0] IRAM_Q,
    output logic          busy,
    output logic          done
);
    localparam int N   = IMG_W*IMG_H;
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int AW1 = AW + 1;

    localparam logic [AW:0]   LP_N     = AW1'(N);
    localparam logic [AW:0]   LP_N1    = AW1'(N + 1);
    localparam logic [AW:0]   LP_ONE   = AW1'(1);
    localparam logic [XW-1:0] LP_X_ONE = XW'(1);
    localparam logic [XW-1:0] LP_X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] LP_Y_ONE = YW'(1);
    localparam logic [YW-1:0] LP_Y_MAX = YW'(IMG_H - 1);

    localparam logic [3:0] C_WRITE  = 4'd0;
    localparam logic [3:0] C_UP     = 4'd1;
    localparam logic [3:0] C_DOWN   = 4'd2;
    localparam logic [3:0] C_LEFT   = 4'd3;
    localparam logic [3:0] C_RIGHT  = 4'd4;
    localparam logic [3:0] C_MAX    = 4'd5;
    localparam logic [3:0] C_MIN    = 4'd6;
    localparam logic [3:0] C_AVG    = 4'd7;
    localparam logic [3:0] C_ROTCCW = 4'd8;
    localparam logic [3:0] C_ROTCW  = 4'd9;
    localparam logic [3:0] C_MIRX   = 4'd10;
    localparam logic [3:0] C_MIRY   = 4'd11;
    localparam logic [3:0] C_RELOAD = 4'd12;

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;

    logic [AW:0]     r_cnt;
    logic            r_irom_rd;
    logic [AW-1:0]   r_irom_a;
    logic            r_cap_en;
    logic [AW-1:0]   r_cap_a;
    logic            r_ceb;
    logic            r_web;
    logic [DW-1:0]   r_iram_d;
    logic [AW-1:0]   r_iram_a;

    logic [3:0]      r_cmd;
    logic [XW-1:0]   r_px;
    logic [YW-1:0]   r_py;
    logic [DW-1:0]   r_buf [N];

    logic [XW-1:0]   w_xm1;
    logic [YW-1:0]   w_ym1;
    logic [AW-1:0]   w_a_tl, w_a_tr, w_a_bl, w_a_br;
    logic [DW-1:0]   w_p_tl, w_p_tr, w_p_bl, w_p_br;
    logic [DW-1:0]   w_max_t, w_max_b, w_max;
    logic [DW-1:0]   w_min_t, w_min_b, w_min;
    logic [DW+1:0]   w_sum;
    logic [DW-1:0]   w_n_tl, w_n_tr, w_n_bl, w_n_br;
    logic            w_win_we;

    // IRAM read data has no use in this block
    logic            w_unused_iram_q;
    assign w_unused_iram_q = ^IRAM_Q;

    // State register; reset always lands at the start of LOAD
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_LOAD;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode and command acceptance
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_LOAD:  if (r_cnt == LP_N1) w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd == C_WRITE)       w_state_nxt = S_WRITE;
                    else if (cmd == C_RELOAD) w_state_nxt = S_LOAD;
                    else                      w_state_nxt = S_EXEC;
                end
            end
            S_EXEC:  w_state_nxt = S_IDLE;
            S_WRITE: if (r_cnt == LP_N) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    // Sequencing counter plus registered IROM/IRAM strobes; Reload and Write
    // issue their first access from the accepting edge so the bursts start
    // on the very next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_irom_rd <= 1'b0;
            r_irom_a  <= '0;
            r_cap_en  <= 1'b0;
            r_cap_a   <= '0;
            r_ceb     <= 1'b0;
            r_web     <= 1'b1;
            r_iram_d  <= '0;
            r_iram_a  <= '0;
        end else begin
            r_cap_en <= r_irom_rd;
            r_cap_a  <= r_irom_a;
            case (r_state)
                S_LOAD: begin
                    if (r_cnt < LP_N) begin
                        r_irom_rd <= 1'b1;
                        r_irom_a  <= r_cnt[AW-1:0];
                        r_cnt     <= r_cnt + LP_ONE;
                    end else if (r_cnt == LP_N) begin
                        r_irom_rd <= 1'b0;
                        r_cnt     <= r_cnt + LP_ONE;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_IDLE: begin
                    if (w_accept && cmd == C_WRITE) begin
                        r_ceb    <= 1'b1;
                        r_web    <= 1'b0;
                        r_iram_a <= '0;
                        r_iram_d <= r_buf[0];
                        r_cnt    <= LP_ONE;
                    end else if (w_accept && cmd == C_RELOAD) begin
                        r_irom_rd <= 1'b1;
                        r_irom_a  <= '0;
                        r_cnt     <= LP_ONE;
                    end
                end
                S_WRITE: begin
                    if (r_cnt < LP_N) begin
                        r_iram_a <= r_cnt[AW-1:0];
                        r_iram_d <= r_buf[r_cnt[AW-1:0]];
                        r_cnt    <= r_cnt + LP_ONE;
                    end else begin
                        r_ceb <= 1'b0;
                        r_web <= 1'b1;
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign IROM_rd  = r_irom_rd;
    assign IROM_A   = r_irom_a;
    assign IRAM_ceb = r_ceb;
    assign IRAM_web = r_web;
    assign IRAM_D   = r_iram_d;
    assign IRAM_A   = r_iram_a;

    // Command latch and operation point; moves that would leave range are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
            r_px  <= XW'(IMG_W/2);
            r_py  <= YW'(IMG_H/2);
        end else begin
            if (w_accept) r_cmd <= cmd;
            if (r_state == S_EXEC) begin
                case (r_cmd)
                    C_UP:    if (r_py != LP_Y_ONE) r_py <= r_py - LP_Y_ONE;
                    C_DOWN:  if (r_py != LP_Y_MAX) r_py <= r_py + LP_Y_ONE;
                    C_LEFT:  if (r_px != LP_X_ONE) r_px <= r_px - LP_X_ONE;
                    C_RIGHT: if (r_px != LP_X_MAX) r_px <= r_px + LP_X_ONE;
                    default: ;
                endcase
            end
        end
    end

    // Window addressing: index = y*IMG_W + x, a plain concatenation for power-of-two widths
    assign w_xm1  = r_px - LP_X_ONE;
    assign w_ym1  = r_py - LP_Y_ONE;
    assign w_a_tl = {w_ym1, w_xm1};
    assign w_a_tr = {w_ym1, r_px};
    assign w_a_bl = {r_py,  w_xm1};
    assign w_a_br = {r_py,  r_px};

    assign w_p_tl = r_buf[w_a_tl];
    assign w_p_tr = r_buf[w_a_tr];
    assign w_p_bl = r_buf[w_a_bl];
    assign w_p_br = r_buf[w_a_br];

    assign w_max_t = (w_p_tl > w_p_tr) ? w_p_tl : w_p_tr;
    assign w_max_b = (w_p_bl > w_p_br) ? w_p_bl : w_p_br;
    assign w_max   = (w_max_t > w_max_b) ? w_max_t : w_max_b;
    assign w_min_t = (w_p_tl < w_p_tr) ? w_p_tl : w_p_tr;
    assign w_min_b = (w_p_bl < w_p_br) ? w_p_bl : w_p_br;
    assign w_min   = (w_min_t < w_min_b) ? w_min_t : w_min_b;
    assign w_sum   = {2'b00, w_p_tl} + {2'b00, w_p_tr} + {2'b00, w_p_bl} + {2'b00, w_p_br};

    // New window contents for the latched window command
    always_comb begin
        w_n_tl   = w_p_tl;
        w_n_tr   = w_p_tr;
        w_n_bl   = w_p_bl;
        w_n_br   = w_p_br;
        w_win_we = 1'b0;
        case (r_cmd)
            C_MAX: begin
                w_n_tl = w_max; w_n_tr = w_max; w_n_bl = w_max; w_n_br = w_max;
                w_win_we = 1'b1;
            end
            C_MIN: begin
                w_n_tl = w_min; w_n_tr = w_min; w_n_bl = w_min; w_n_br = w_min;
                w_win_we = 1'b1;
            end
            C_AVG: begin
                w_n_tl = w_sum[DW+1:2]; w_n_tr = w_sum[DW+1:2];
                w_n_bl = w_sum[DW+1:2]; w_n_br = w_sum[DW+1:2];
                w_win_we = 1'b1;
            end
            C_ROTCCW: begin
                w_n_tl = w_p_tr; w_n_tr = w_p_br; w_n_br = w_p_bl; w_n_bl = w_p_tl;
                w_win_we = 1'b1;
            end
            C_ROTCW: begin
                w_n_tl = w_p_bl; w_n_bl = w_p_br; w_n_br = w_p_tr; w_n_tr = w_p_tl;
                w_win_we = 1'b1;
            end
            C_MIRX: begin
                w_n_tl = w_p_bl; w_n_bl = w_p_tl; w_n_tr = w_p_br; w_n_br = w_p_tr;
                w_win_we = 1'b1;
            end
            C_MIRY: begin
                w_n_tl = w_p_tr; w_n_tr = w_p_tl; w_n_bl = w_p_br; w_n_br = w_p_bl;
                w_win_we = 1'b1;
            end
            default: ;
        endcase
    end

    // Image buffer: IROM capture during LOAD, window update at the end of EXEC
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_cap_en) r_buf[r_cap_a] <= IROM_Q;
            if (r_state == S_EXEC && w_win_we) begin
                r_buf[w_a_tl] <= w_n_tl;
                r_buf[w_a_tr] <= w_n_tr;
                r_buf[w_a_bl] <= w_n_bl;
                r_buf[w_a_br] <= w_n_br;
            end
        end
    end

endmodule
